// File: rtl/regfile_scoreboard_if.sv
// Bundle of writeback, issue and read-port signals between ID/WB and the register file.
// The master side (ID/WB stages) drives addresses and data; the register file is the slave.
interface regfile_scoreboard_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
);
   logic                     wr_en;
   logic [ADDR_W-1:0]        wr_addr;
   logic [DATA_W-1:0]        wr_data;
   logic                     iss_en;
   logic [ADDR_W-1:0]        iss_addr;
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;
   logic [ADDR_W:0]          pend_cnt;

   // No valid/ready handshake: wr_en and iss_en are single-cycle strobes sampled
   // on the rising edge, and the read ports are purely combinational lookups.
   modport master (
      output wr_en, wr_addr, wr_data, iss_en, iss_addr, rd_addr,
      input  rd_data, rd_busy, pend_cnt
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, iss_en, iss_addr, rd_addr,
      output rd_data, rd_busy, pend_cnt
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file (r0 hardwired to zero) with a per-register pending scoreboard.
// Optional macro RF_BYPASS_EN forwards the same-cycle writeback value to matching read ports.
module regfile_scoreboard #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   regfile_scoreboard_if.slave   bus
);
   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0]        mem_q [DEPTH];
   logic [DEPTH-1:0]         pending_q, pending_d;
   logic [ADDR_W:0]          pend_cnt_q, pend_cnt_d;
   logic                     set_hit, clr_hit, wr_hit;
   logic [ADDR_W-1:0]        ra;
   logic [NUM_RD*DATA_W-1:0] rd_data_c;
   logic [NUM_RD-1:0]        rd_busy_c;

   assign wr_hit  = bus.wr_en && (bus.wr_addr != '0);
   assign set_hit = bus.iss_en && (bus.iss_addr != '0);
   // A same-edge issue to the written register wins: a new producer is in flight.
   assign clr_hit = wr_hit && !(set_hit && (bus.iss_addr == bus.wr_addr));

   always_comb begin
      pending_d = pending_q;
      if (clr_hit) pending_d[bus.wr_addr] = 1'b0;
      if (set_hit) pending_d[bus.iss_addr] = 1'b1;
      pend_cnt_d = pend_cnt_q
                 + (ADDR_W+1)'(set_hit && !pending_q[bus.iss_addr])
                 - (ADDR_W+1)'(clr_hit && pending_q[bus.wr_addr]);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending_q  <= '0;
         pend_cnt_q <= '0;
      end else begin
         pending_q  <= pending_d;
         pend_cnt_q <= pend_cnt_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (wr_hit) begin
         mem_q[bus.wr_addr] <= bus.wr_data;
      end
   end

   always_comb begin
      rd_data_c = '0;
      rd_busy_c = '0;
      ra        = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         ra = bus.rd_addr[p*ADDR_W +: ADDR_W];
         if (!reset && (ra != '0)) begin
            rd_data_c[p*DATA_W +: DATA_W] = mem_q[ra];
            rd_busy_c[p]                  = pending_q[ra];
`ifdef RF_BYPASS_EN
            // Forward WB data; busy clears unless the same register is being reissued.
            if (wr_hit && (ra == bus.wr_addr)) begin
               rd_data_c[p*DATA_W +: DATA_W] = bus.wr_data;
               if (!(set_hit && (bus.iss_addr == bus.wr_addr))) rd_busy_c[p] = 1'b0;
            end
`else
            // Without forwarding, the WB value appears the cycle after the write edge.
`endif
         end
      end
   end

   assign bus.rd_data  = rd_data_c;
   assign bus.rd_busy  = rd_busy_c;
   assign bus.pend_cnt = pend_cnt_q;
endmodule
